// File: rtl/prng_pkg.sv
// Shared PRNG definitions: 16-bit XNOR LFSR width, taps, lockup value, checker states.
package prng_pkg;

    localparam int unsigned LFSR16_W     = 16;
    localparam int unsigned LFSR16_TAP_A = 15;
    localparam int unsigned LFSR16_TAP_B = 14;
    localparam int unsigned LFSR16_TAP_C = 12;
    localparam int unsigned LFSR16_TAP_D = 3;

    localparam logic [LFSR16_W-1:0] LFSR16_LOCKUP = 16'hFFFF;

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } chk_state_e;

endpackage

// File: rtl/lfsr16_next.sv
// Feedback bit of the 16-bit XNOR LFSR; the single tap definition shared by generator and checker.
module lfsr16_next
    import prng_pkg::*;
(
    input  logic [LFSR16_W-1:0] i_s,
    output logic                o_exp_c
);

    assign o_exp_c = ~(i_s[LFSR16_TAP_A] ^ i_s[LFSR16_TAP_B] ^
                       i_s[LFSR16_TAP_C] ^ i_s[LFSR16_TAP_D]);

endmodule

// File: rtl/lfsr16_checker.sv
// Serial checker for the 16-bit XNOR LFSR stream: self-seeds, predicts, counts errors, tracks lock.
module lfsr16_checker
    import prng_pkg::*;
#(
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam int unsigned WIN_W  = $clog2(WINDOW);
    localparam int unsigned WERR_W = $clog2(WINDOW + 1);
    localparam int unsigned SCNT_W = $clog2(LFSR16_W);
    localparam int unsigned ECNT_W = 16;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] LOSS_LIM  = WERR_W'(LOSS_THRESH);
    localparam logic [SCNT_W-1:0] SEED_LAST = SCNT_W'(LFSR16_W - 1);

    chk_state_e          r_state,      w_state_nxt;
    logic [LFSR16_W-1:0] r_s,          w_s_nxt;
    logic [SCNT_W-1:0]   r_seed_cnt,   w_seed_cnt_nxt;
    logic [WIN_W-1:0]    r_win_cnt,    w_win_cnt_nxt;
    logic [WERR_W-1:0]   r_win_err,    w_win_err_nxt;
    logic                r_locked,     w_locked_nxt;
    logic                r_err_pulse,  w_err_pulse_nxt;
    logic [ECNT_W-1:0]   r_err_count,  w_err_count_nxt;

    logic                w_exp;
    logic                w_accept;
    logic                w_clear;
    logic                w_mismatch;
    logic [WERR_W-1:0]   w_win_err_inc;

    assign w_accept = ena & bit_valid;
    assign w_clear  = ena & clear_cnt;

    lfsr16_next u_next (
        .i_s     (r_s),
        .o_exp_c (w_exp)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SEED;
            r_s         <= '0;
            r_seed_cnt  <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_seed_cnt  <= w_seed_cnt_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_win_err   <= w_win_err_nxt;
            r_locked    <= w_locked_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    // Next-state: seeding, prediction, error counting and lock-loss windowing.
    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_seed_cnt_nxt  = r_seed_cnt;
        w_win_cnt_nxt   = r_win_cnt;
        w_win_err_nxt   = r_win_err;
        w_err_pulse_nxt = 1'b0;
        w_err_count_nxt = r_err_count;
        w_mismatch      = 1'b0;
        w_win_err_inc   = r_win_err;

        if (w_clear) begin
            w_err_count_nxt = '0;
        end

        if (w_accept) begin
            if (r_state == SEED) begin
                w_s_nxt = {r_s[LFSR16_W-2:0], bit_in};
                if (r_seed_cnt == SEED_LAST) begin
                    // All-ones seed would lock the XNOR LFSR; take a fresh seed instead.
                    w_seed_cnt_nxt = '0;
                    if (w_s_nxt != LFSR16_LOCKUP) begin
                        w_state_nxt   = CHECK;
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end
                end else begin
                    w_seed_cnt_nxt = r_seed_cnt + SCNT_W'(1);
                end
            end else begin
                w_s_nxt       = {r_s[LFSR16_W-2:0], w_exp};
                w_mismatch    = (bit_in != w_exp);
                w_win_err_inc = r_win_err + WERR_W'(w_mismatch);
                if (w_mismatch) begin
                    w_err_pulse_nxt = 1'b1;
                    if (w_clear) begin
                        w_err_count_nxt = ECNT_W'(1);
                    end else if (r_err_count != '1) begin
                        w_err_count_nxt = r_err_count + ECNT_W'(1);
                    end
                end
                // Loss of lock wins over the window wrap on the same bit.
                if (w_mismatch && (w_win_err_inc == LOSS_LIM)) begin
                    w_state_nxt    = SEED;
                    w_seed_cnt_nxt = '0;
                    w_win_cnt_nxt  = '0;
                    w_win_err_nxt  = '0;
                end else if (r_win_cnt == WIN_LAST) begin
                    w_win_cnt_nxt = '0;
                    w_win_err_nxt = '0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + WIN_W'(1);
                    w_win_err_nxt = w_win_err_inc;
                end
            end
        end

        w_locked_nxt = (w_state_nxt == CHECK);
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
